watch_edit_controller: RTL and testbench

- Sequences the watch time-setting datapath by generating its cursor (`o_cursor`) and the up/down button levels.
- Arbitrates between two requesters: the physical buttons (already debounced levels) and single-byte commands decoded from the UART RX path.
- Returns the watch to run mode after a configurable period with no activity.
- Sits between the button debouncers / UART RX and the watch datapath.

---
 rtl/watch_edit_controller.sv | 169 ++++++++++++++++
 tb/tb_watch_edit_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_edit_controller.sv
// Edit-mode sequencer for the watch: cursor stepping, idle timeout, and arbitration
// of up/down levels between the physical buttons and UART-synthesized presses.
module watch_edit_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
    parameter int unsigned PRESS_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_uart_valid,
    input  logic [7:0] i_uart_cmd,
    output logic [2:0] o_cursor,
    output logic       o_btn_up,
    output logic       o_btn_down,
    output logic       o_uart_busy
);
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned PC_W = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX   = '1;
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PRESS_CYCLES - 1);
    localparam logic [2:0]      CUR_LAST = 3'd4;
    localparam logic [7:0]      CMD_M    = 8'h4D;
    localparam logic [7:0]      CMD_R    = 8'h52;
    localparam logic [7:0]      CMD_U    = 8'h55;
    localparam logic [7:0]      CMD_D    = 8'h44;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_PRESS = 2'd1,
        U_GAP   = 2'd2
    } u_state_t;

    logic            r_mode_q;
    logic [2:0]      r_cursor;
    logic [TO_W-1:0] r_to_cnt;
    u_state_t        r_state;
    logic [PC_W-1:0] r_press_cnt;
    logic            r_dir_up;
    logic            r_btn_up;
    logic            r_btn_down;
    logic            r_busy;

    logic            w_mode_edge;
    logic            w_cmd_m;
    logic            w_cmd_r;
    logic            w_cmd_u;
    logic            w_cmd_d;
    logic            w_phys;
    logic            w_activity;
    logic            w_expire;
    logic [2:0]      w_cursor_nxt;
    logic [TO_W-1:0] w_to_nxt;
    u_state_t        w_state_nxt;
    logic [PC_W-1:0] w_press_cnt_nxt;
    logic            w_dir_up_nxt;
    logic            w_btn_up_nxt;
    logic            w_btn_down_nxt;

    assign w_mode_edge = i_btn_mode & ~r_mode_q;
    assign w_cmd_m     = i_uart_valid & (i_uart_cmd == CMD_M);
    assign w_cmd_r     = i_uart_valid & (i_uart_cmd == CMD_R);
    assign w_cmd_u     = i_uart_valid & (i_uart_cmd == CMD_U);
    assign w_cmd_d     = i_uart_valid & (i_uart_cmd == CMD_D);
    assign w_phys      = i_btn_up | i_btn_down;
    assign w_activity  = w_mode_edge | w_phys | w_cmd_m | w_cmd_r | w_cmd_u | w_cmd_d;
    assign w_expire    = (r_cursor != 3'd0) && (r_to_cnt == TO_LAST);

    // Cursor stepping and idle timeout; expiry outranks reset-to-run, which outranks advance.
    always_comb begin
        w_cursor_nxt = r_cursor;
        w_to_nxt     = r_to_cnt;
        if (w_expire || w_cmd_r) begin
            w_cursor_nxt = 3'd0;
        end else if (w_mode_edge || w_cmd_m) begin
            w_cursor_nxt = (r_cursor >= CUR_LAST) ? 3'd0 : r_cursor + 3'd1;
        end
        if ((r_cursor == 3'd0) || w_expire || w_activity) begin
            w_to_nxt = '0;
        end else if (r_to_cnt != TO_MAX) begin
            w_to_nxt = r_to_cnt + TO_W'(1);
        end
    end

    // UART press FSM next state plus arbitrated button levels.
    always_comb begin
        w_state_nxt     = r_state;
        w_press_cnt_nxt = r_press_cnt;
        w_dir_up_nxt    = r_dir_up;
        w_btn_up_nxt    = 1'b0;
        w_btn_down_nxt  = 1'b0;

        case (r_state)
            U_IDLE: begin
                if ((w_cmd_u || w_cmd_d) && (r_cursor != 3'd0) && !w_phys) begin
                    w_state_nxt     = U_PRESS;
                    w_press_cnt_nxt = '0;
                    w_dir_up_nxt    = w_cmd_u;
                end
            end
            U_PRESS: begin
                if (w_phys || (r_cursor == 3'd0) || (r_press_cnt == PC_LAST)) begin
                    w_state_nxt     = U_GAP;
                    w_press_cnt_nxt = '0;
                end else begin
                    w_press_cnt_nxt = r_press_cnt + PC_W'(1);
                end
            end
            U_GAP: begin
                if (r_press_cnt == PC_LAST) begin
                    w_state_nxt     = U_IDLE;
                    w_press_cnt_nxt = '0;
                end else begin
                    w_press_cnt_nxt = r_press_cnt + PC_W'(1);
                end
            end
            default: begin
                w_state_nxt     = U_IDLE;
                w_press_cnt_nxt = '0;
            end
        endcase

        if (w_cursor_nxt == 3'd0) begin
            w_btn_up_nxt   = 1'b0;
            w_btn_down_nxt = 1'b0;
        end else if (i_btn_up && i_btn_down) begin
            w_btn_up_nxt   = 1'b0;
            w_btn_down_nxt = 1'b0;
        end else if (w_phys) begin
            w_btn_up_nxt   = i_btn_up;
            w_btn_down_nxt = i_btn_down;
        end else if (w_state_nxt == U_PRESS) begin
            w_btn_up_nxt   = w_dir_up_nxt;
            w_btn_down_nxt = ~w_dir_up_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode_q    <= 1'b0;
            r_cursor    <= 3'd0;
            r_to_cnt    <= '0;
            r_state     <= U_IDLE;
            r_press_cnt <= '0;
            r_dir_up    <= 1'b0;
            r_btn_up    <= 1'b0;
            r_btn_down  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_mode_q    <= i_btn_mode;
            r_cursor    <= w_cursor_nxt;
            r_to_cnt    <= w_to_nxt;
            r_state     <= w_state_nxt;
            r_press_cnt <= w_press_cnt_nxt;
            r_dir_up    <= w_dir_up_nxt;
            r_btn_up    <= w_btn_up_nxt;
            r_btn_down  <= w_btn_down_nxt;
            r_busy      <= (w_state_nxt != U_IDLE);
        end
    end

    assign o_cursor    = r_cursor;
    assign o_btn_up    = r_btn_up;
    assign o_btn_down  = r_btn_down;
    assign o_uart_busy = r_busy;

endmodule

// File: tb/tb_watch_edit_controller.sv
// Bench for watch_edit_controller: directed scenarios with literal expectations, then
// random stimulus compared every cycle against a timestamp-based reference model.
module tb_watch_edit_controller;
    localparam int unsigned T_CYC = 50;
    localparam int unsigned P_CYC = 8;
    localparam int          IDLE_MAX = (1 << $clog2(T_CYC)) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_up, btn_down, uart_valid;
    logic [7:0] uart_cmd;
    logic [2:0] cursor;
    logic       out_up, out_down, busy;

    int n_checks = 0;
    int n_errors = 0;

    watch_edit_controller #(.TIMEOUT_CYCLES(T_CYC), .PRESS_CYCLES(P_CYC)) dut (
        .clk(clk), .reset(reset),
        .i_btn_mode(btn_mode), .i_btn_up(btn_up), .i_btn_down(btn_down),
        .i_uart_valid(uart_valid), .i_uart_cmd(uart_cmd),
        .o_cursor(cursor), .o_btn_up(out_up), .o_btn_down(out_down), .o_uart_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: press/busy windows are tracked as absolute edge timestamps.
    int  t = 0;
    int  m_cursor = 0, m_idle = 0;
    bit  m_mode_prev = 0, m_dir_up = 0;
    int  press_start = 0, press_end = -1, busy_end = -1;
    bit  e_up = 0, e_down = 0, e_busy = 0;
    bit  me, is_m, is_r, is_ud, phys, act, expire, pressing_prev, busy_prev, pressing_now;
    int  cur_prev;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cursor = 0; m_idle = 0; m_mode_prev = 0; m_dir_up = 0;
            press_start = 0; press_end = -1; busy_end = -1;
            e_up = 0; e_down = 0; e_busy = 0;
        end else begin
            t++;
            me = btn_mode && !m_mode_prev;
            m_mode_prev = btn_mode;
            is_m  = uart_valid && uart_cmd == 8'h4D;
            is_r  = uart_valid && uart_cmd == 8'h52;
            is_ud = uart_valid && (uart_cmd == 8'h55 || uart_cmd == 8'h44);
            phys  = btn_up || btn_down;
            act   = me || phys || is_m || is_r || is_ud;
            expire = (m_cursor != 0) && (m_idle == int'(T_CYC) - 1);
            pressing_prev = (t - 1 >= press_start) && (t - 1 <= press_end);
            busy_prev = (t - 1 <= busy_end);
            cur_prev = m_cursor;

            if (expire || is_r) m_cursor = 0;
            else if (me || is_m) m_cursor = (m_cursor + 1) % 5;

            if (cur_prev == 0 || expire || act) m_idle = 0;
            else if (m_idle < IDLE_MAX) m_idle++;

            if (!busy_prev) begin
                if (is_ud && cur_prev != 0 && !phys) begin
                    press_start = t;
                    press_end   = t + int'(P_CYC) - 1;
                    busy_end    = t + 2 * int'(P_CYC) - 1;
                    m_dir_up    = (uart_cmd == 8'h55);
                end
            end else if (pressing_prev && t <= press_end && (phys || cur_prev == 0)) begin
                press_end = t - 1;
                busy_end  = t - 1 + int'(P_CYC);
            end
            pressing_now = (t >= press_start) && (t <= press_end);
            e_busy = (t <= busy_end);

            e_up = 0; e_down = 0;
            if (m_cursor == 0 || (btn_up && btn_down)) begin
                e_up = 0; e_down = 0;
            end else if (phys) begin
                e_up = btn_up; e_down = btn_down;
            end else if (pressing_now) begin
                e_up = m_dir_up; e_down = !m_dir_up;
            end
        end
    end

    always @(negedge clk) begin
        check("model_cursor", int'(cursor), m_cursor);
        check("model_up", int'(out_up), int'(e_up));
        check("model_down", int'(out_down), int'(e_down));
        check("model_busy", int'(busy), int'(e_busy));
        check("up_down_exclusive", int'(out_up & out_down), 0);
    end

    task automatic mode_edge();
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c);
        uart_valid = 1'b1;
        uart_cmd   = c;
        @(negedge clk);
        uart_valid = 1'b0;
    endtask

    int r;

    initial begin
        reset = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        uart_valid = 1'b0; uart_cmd = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cursor", int'(cursor), 0);
        check("rst_up", int'(out_up), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;
        @(negedge clk);

        // Five held mode presses: one step each, 1,2,3,4,0.
        for (int k = 0; k < 5; k++) begin
            btn_mode = 1'b1;
            @(negedge clk);
            check("mode_step", int'(cursor), (k + 1) % 5);
            repeat (9) @(negedge clk);
            check("mode_hold", int'(cursor), (k + 1) % 5);
            btn_mode = 1'b0;
            repeat (10) @(negedge clk);
        end

        // UART 'U' press at cursor 1, with a 'D' dropped while busy.
        mode_edge();
        check("cursor_one", int'(cursor), 1);
        send(8'h55);
        for (int i = 0; i < 16; i++) begin
            check("uart_up_window", int'(out_up), (i < 8) ? 1 : 0);
            check("uart_busy_window", int'(busy), 1);
            check("uart_d_dropped", int'(out_down), 0);
            uart_valid = (i == 2);
            uart_cmd   = 8'h44;
            @(negedge clk);
        end
        uart_valid = 1'b0;
        check("uart_idle_after", int'(busy), 0);
        check("uart_up_after", int'(out_up), 0);

        // Cursor 0 suppresses everything; conflict at cursor 3 suppresses both.
        send(8'h52);
        check("r_to_run", int'(cursor), 0);
        send(8'h55);
        check("run_u_up", int'(out_up), 0);
        check("run_u_busy", int'(busy), 0);
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        check("run_phys_up", int'(out_up), 0);
        btn_up = 1'b0;
        repeat (3) mode_edge();
        check("cursor_three", int'(cursor), 3);
        btn_up = 1'b1; btn_down = 1'b1;
        repeat (2) @(negedge clk);
        check("conflict_up", int'(out_up), 0);
        check("conflict_down", int'(out_down), 0);
        btn_up = 1'b0; btn_down = 1'b0;

        // Timeout: plain, with a non-command byte, and restarted by 'M'.
        send(8'h52);
        repeat (2) mode_edge();
        repeat (48) @(negedge clk);
        check("to_before", int'(cursor), 2);
        @(negedge clk);
        check("to_at_50", int'(cursor), 0);

        repeat (2) mode_edge();
        repeat (29) @(negedge clk);
        send(8'h41);
        repeat (18) @(negedge clk);
        check("to_41_before", int'(cursor), 2);
        @(negedge clk);
        check("to_41_at_50", int'(cursor), 0);

        repeat (2) mode_edge();
        repeat (29) @(negedge clk);
        send(8'h4D);
        check("to_m_step", int'(cursor), 3);
        repeat (49) @(negedge clk);
        check("to_m_before", int'(cursor), 3);
        @(negedge clk);
        check("to_m_at_50", int'(cursor), 0);

        // Same-cycle conflicts.
        repeat (3) mode_edge();
        btn_mode = 1'b1; uart_valid = 1'b1; uart_cmd = 8'h52;
        @(negedge clk);
        uart_valid = 1'b0;
        check("r_beats_edge", int'(cursor), 0);
        btn_mode = 1'b0;
        @(negedge clk);
        mode_edge();
        btn_mode = 1'b1; uart_valid = 1'b1; uart_cmd = 8'h4D;
        @(negedge clk);
        uart_valid = 1'b0;
        check("m_and_edge_once", int'(cursor), 2);
        btn_mode = 1'b0;
        @(negedge clk);

        // Async reset in the middle of a UART press at cursor 3.
        send(8'h52);
        repeat (3) mode_edge();
        send(8'h55);
        @(negedge clk);
        check("press_live_up", int'(out_up), 1);
        #2 reset = 1'b0;
        #1;
        check("async_cursor", int'(cursor), 0);
        check("async_up", int'(out_up), 0);
        check("async_down", int'(out_down), 0);
        check("async_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_cursor", int'(cursor), 0);
        check("post_rst_busy", int'(busy), 0);

        // Random phase: busy blocks alternate with quiet blocks so timeouts occur.
        for (int blk = 0; blk < 12; blk++) begin
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 11) == 0) btn_mode = ~btn_mode;
                if (blk % 3 == 2) begin
                    btn_up = 1'b0; btn_down = 1'b0;
                    uart_valid = ($urandom_range(0, 30) == 0);
                    uart_cmd = 8'h41;
                end else begin
                    if (btn_up) btn_up = ($urandom_range(0, 3) != 0);
                    else        btn_up = ($urandom_range(0, 39) == 0);
                    if (btn_down) btn_down = ($urandom_range(0, 3) != 0);
                    else          btn_down = ($urandom_range(0, 39) == 0);
                    uart_valid = ($urandom_range(0, 5) == 0);
                    r = int'($urandom_range(0, 19));
                    if (r < 7)       uart_cmd = 8'h4D;
                    else if (r == 7) uart_cmd = 8'h52;
                    else if (r < 13) uart_cmd = 8'h55;
                    else if (r < 17) uart_cmd = 8'h44;
                    else             uart_cmd = 8'($urandom_range(0, 255));
                end
                @(negedge clk);
            end
        end
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; uart_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
